// File: rtl/id_decode_stage.sv
// Instruction decode stage: registers a decoded RV32I(+M) bundle behind a
// valid/ready handshake, with an optional skid entry so in_ready is a flop.
module id_decode_stage #(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b0,
  parameter bit SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_mem_read,
  output logic            out_mem_to_reg,
  output logic            out_alu_src,
  output logic            out_reg_write,
  output logic [1:0]      out_mem_write,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [5:0]      ctl;       // {branch,jump,mem_read,mem_to_reg,alu_src,reg_write}
    logic [1:0]      mem_write;
    logic            illegal;
  } bundle_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Pure decode of one instruction word into the output bundle.
  function automatic bundle_t decode(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    bundle_t            b;
    logic [5:0]         ctl;
    logic [1:0]         mw;
    logic               ill;
    logic signed [31:0] imm32;
    logic [2:0]         f3;
    logic [6:0]         f7;
    f3    = ins[14:12];
    f7    = ins[31:25];
    ctl   = 6'b000000;
    mw    = 2'b00;
    ill   = 1'b0;
    imm32 = '0;
    case (ins[6:0])
      OPC_LUI, OPC_AUIPC: begin
        ctl   = 6'b000011;
        imm32 = {ins[31:12], 12'b0};
      end
      OPC_JAL: begin
        ctl   = 6'b010011;
        imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OPC_JALR: begin
        ctl   = 6'b010011;
        imm32 = {{20{ins[31]}}, ins[31:20]};
        ill   = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        ctl   = 6'b100000;
        imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ill   = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        ctl   = 6'b001111;
        imm32 = {{20{ins[31]}}, ins[31:20]};
        ill   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        ctl   = 6'b000010;
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        case (f3)
          3'b000:  mw = 2'b01;
          3'b001:  mw = 2'b10;
          3'b010:  mw = 2'b11;
          default: ill = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        ctl   = 6'b000011;
        imm32 = {{20{ins[31]}}, ins[31:20]};
        if (f3 == 3'b001)
          ill = (f7 != 7'b0000000);
        else if (f3 == 3'b101)
          ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
      end
      OPC_OP: begin
        ctl = 6'b000001;
        ill = !((f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
                ((f7 == 7'b0000001) && EN_M));
      end
      default: ill = 1'b1;
    endcase
    // An illegal beat still flows down the pipe but must not act on anything.
    if (ill) begin
      ctl = 6'b000000;
      mw  = 2'b00;
    end
    // Writes to x0 are dropped here so later stages never see them.
    if (ins[11:7] == 5'd0)
      ctl[0] = 1'b0;
    b.pc        = pc;
    b.rs1       = ins[19:15];
    b.rs2       = ins[24:20];
    b.rd        = ins[11:7];
    b.funct3    = f3;
    b.funct7    = f7;
    b.imm       = XLEN'(imm32);
    b.ctl       = ctl;
    b.mem_write = mw;
    b.illegal   = ill;
    return b;
  endfunction

  bundle_t main_q, main_d, skid_q, skid_d, dec;
  logic    vld_main_q, vld_main_d, vld_skid_q, vld_skid_d;
  logic    accept, out_xfer;

  assign dec      = decode(in_instr, in_pc);
  assign in_ready = SKID ? !vld_skid_q : (!vld_main_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign out_xfer = vld_main_q && out_ready;

  // Next-state of the main/skid entries; flush wins over any transfer.
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    vld_main_d = vld_main_q;
    vld_skid_d = vld_skid_q;
    if (flush) begin
      vld_main_d = 1'b0;
      vld_skid_d = 1'b0;
    end else if (SKID) begin
      if (!vld_main_q) begin
        if (accept) begin
          main_d     = dec;
          vld_main_d = 1'b1;
        end
      end else if (out_xfer) begin
        if (vld_skid_q) begin
          main_d     = skid_q;
          vld_skid_d = 1'b0;
        end else if (accept) begin
          main_d = dec;
        end else begin
          vld_main_d = 1'b0;
        end
      end else if (accept) begin
        skid_d     = dec;
        vld_skid_d = 1'b1;
      end
    end else begin
      if (accept) begin
        main_d     = dec;
        vld_main_d = 1'b1;
      end else if (out_xfer) begin
        vld_main_d = 1'b0;
      end
    end
  end

  // Occupancy flags: the only state that reset touches.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_main_q <= 1'b0;
      vld_skid_q <= 1'b0;
    end else begin
      vld_main_q <= vld_main_d;
      vld_skid_q <= vld_skid_d;
    end
  end

  // Bundle payload registers; meaningless whenever their valid flag is low.
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

  assign out_valid      = vld_main_q;
  assign out_pc         = main_q.pc;
  assign out_rs1        = main_q.rs1;
  assign out_rs2        = main_q.rs2;
  assign out_rd         = main_q.rd;
  assign out_funct3     = main_q.funct3;
  assign out_funct7     = main_q.funct7;
  assign out_imm        = main_q.imm;
  // Control outputs are qualified by valid so an empty stage issues nothing.
  assign out_branch     = vld_main_q && main_q.ctl[5];
  assign out_jump       = vld_main_q && main_q.ctl[4];
  assign out_mem_read   = vld_main_q && main_q.ctl[3];
  assign out_mem_to_reg = vld_main_q && main_q.ctl[2];
  assign out_alu_src    = vld_main_q && main_q.ctl[1];
  assign out_reg_write  = vld_main_q && main_q.ctl[0];
  assign out_mem_write  = vld_main_q ? main_q.mem_write : 2'b00;
  assign out_illegal    = vld_main_q && main_q.illegal;

endmodule
